// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 set-2 keyboard event queue.
package ps2_pkg;

  // One decoded key event as stored in the FIFO.
  typedef struct packed {
    logic       extended;
    logic       is_release;
    logic [7:0] key_number;
  } t_ps2_key_event;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_REL   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Bytes swallowed after the E1 that opens the Pause sequence.
  localparam logic [2:0] PauseSkip = 3'd7;

  typedef enum logic [1:0] {IDLE, REL, PAUSE} t_kbd_state;

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO of key events. The parent qualifies wr_en_i/rd_en_i, so no
// full/empty protection is done here.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DepthLog2 = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 wr_en_i,
  input  t_ps2_key_event       wr_data_i,
  input  logic                 rd_en_i,
  output t_ps2_key_event       rd_data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DepthLog2:0]   count_o
);

  localparam int unsigned         Depth    = 1 << DepthLog2;
  localparam logic [DepthLog2:0]  DepthCnt = (DepthLog2 + 1)'(Depth);

  t_ps2_key_event         mem_q [Depth];
  logic [DepthLog2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DepthLog2:0]     count_q;

  // Storage write; no reset needed since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en_i, rd_en_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == DepthCnt);
  assign count_o   = count_q;

endmodule

// File: rtl/ps2_host_keyboard_queue.sv
// PS/2 set-2 scan-code assembler: folds E0/F0/E1 prefixes into key events,
// optionally filters typematic repeats, and queues events for a slow consumer.
module ps2_host_keyboard_queue
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = 3,
  parameter bit          FILTER_REPEATS  = 1'b0,
  parameter logic [7:0]  PAUSE_KEY_CODE  = 8'hE1
) (
  input  logic                     clk,
  input  logic                     clk__enable,
  input  logic                     reset,
  input  logic                     ps2_rx_data__valid,
  input  logic [7:0]               ps2_rx_data__data,
  input  logic                     ps2_rx_data__parity_error,
  input  logic                     ps2_rx_data__protocol_error,
  input  logic                     ps2_rx_data__timeout,
  input  logic                     ps2_key_ack,
  input  logic                     overflow_clear,
  output logic                     ps2_key__valid,
  output logic                     ps2_key__extended,
  output logic                     ps2_key__release,
  output logic [7:0]               ps2_key__key_number,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     overflow,
  output logic [7:0]               error_count
);

  t_kbd_state     state_q, state_d;
  logic           ext_q, ext_d, rel_q, rel_d;
  logic [2:0]     skip_q, skip_d;
  logic           lm_valid_q, lm_valid_d;
  logic [8:0]     lm_q, lm_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic           overflow_q, overflow_d;

  logic           byte_en, byte_err, emit, is_make, drop, wr_req, pop, fifo_wr;
  logic           fifo_full, fifo_empty;
  t_ps2_key_event evt, head;

  assign byte_en  = ps2_rx_data__valid & clk__enable;
  assign byte_err = ps2_rx_data__parity_error | ps2_rx_data__protocol_error |
                    ps2_rx_data__timeout;

  // Prefix decoder: next state, prefix flags and the event to emit.
  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    rel_d   = rel_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    evt     = '0;
    if (byte_en) begin
      if (byte_err) begin
        state_d = IDLE;
        ext_d   = 1'b0;
        rel_d   = 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (ps2_rx_data__data == PS2_EXT) begin
              ext_d = 1'b1;
            end else if (ps2_rx_data__data == PS2_REL) begin
              rel_d   = 1'b1;
              state_d = REL;
            end else if (ps2_rx_data__data == PS2_PAUSE) begin
              skip_d  = PauseSkip;
              state_d = PAUSE;
            end else begin
              emit  = 1'b1;
              evt   = '{extended: ext_q, is_release: 1'b0, key_number: ps2_rx_data__data};
              ext_d = 1'b0;
            end
          end
          REL: begin
            if (ps2_rx_data__data == PS2_EXT) begin
              ext_d = 1'b1;
            end else if (ps2_rx_data__data != PS2_REL) begin
              emit    = 1'b1;
              evt     = '{extended: ext_q, is_release: 1'b1, key_number: ps2_rx_data__data};
              ext_d   = 1'b0;
              rel_d   = 1'b0;
              state_d = IDLE;
            end
          end
          PAUSE: begin
            skip_d = skip_q - 1'b1;
            if (skip_q == 3'd1) begin
              emit    = 1'b1;
              evt     = '{extended: 1'b0, is_release: 1'b0, key_number: PAUSE_KEY_CODE};
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Repeat filter, FIFO write/pop qualification, overflow and error counting.
  always_comb begin
    is_make    = emit & ~evt.is_release;
    drop       = FILTER_REPEATS & is_make & lm_valid_q &
                 (lm_q == {evt.extended, evt.key_number});
    lm_valid_d = lm_valid_q;
    lm_d       = lm_q;
    if (is_make && !drop) begin
      lm_valid_d = 1'b1;
      lm_d       = {evt.extended, evt.key_number};
    end else if (emit && evt.is_release && lm_valid_q &&
                 (lm_q == {evt.extended, evt.key_number})) begin
      lm_valid_d = 1'b0;
    end

    wr_req  = emit & ~drop;
    pop     = clk__enable & ~fifo_empty & ps2_key_ack;
    // A pop on the same edge frees the slot the write needs.
    fifo_wr = wr_req & (~fifo_full | pop);

    overflow_d = overflow_q;
    if (clk__enable && overflow_clear) overflow_d = 1'b0;
    if (wr_req && fifo_full && !pop)   overflow_d = 1'b1;

    err_cnt_d = err_cnt_q;
    if (byte_en && byte_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // State registers; clock enable freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      skip_q     <= '0;
      lm_valid_q <= 1'b0;
      lm_q       <= '0;
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else if (clk__enable) begin
      state_q    <= state_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      skip_q     <= skip_d;
      lm_valid_q <= lm_valid_d;
      lm_q       <= lm_d;
      err_cnt_q  <= err_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_event_fifo #(
    .DepthLog2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (fifo_wr),
    .wr_data_i (evt),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Head fields read as zero while empty so stale storage never shows.
  assign ps2_key__valid      = ~fifo_empty;
  assign ps2_key__extended   = ~fifo_empty & head.extended;
  assign ps2_key__release    = ~fifo_empty & head.is_release;
  assign ps2_key__key_number = fifo_empty ? 8'h00 : head.key_number;
  assign overflow            = overflow_q;
  assign error_count         = err_cnt_q;

endmodule

// File: tb/tb_ps2_host_keyboard_queue.sv
// Bench: two DUTs (repeat filter off/on) share stimulus; a queue-level model
// predicts every output each cycle, and literal checks pin the model.
module tb_ps2_host_keyboard_queue;

  logic       clk = 1'b0;
  logic       cen, rst, vld, perr, prerr, tmo, ack, oclr;
  logic [7:0] dat;

  logic       v0, x0, r0, o0, v1, x1, r1, o1;
  logic [7:0] k0, k1, e0, e1;
  logic [3:0] c0, c1;

  always #5 clk = ~clk;

  ps2_host_keyboard_queue #(
    .FIFO_DEPTH_LOG2 (3),
    .FILTER_REPEATS  (1'b0),
    .PAUSE_KEY_CODE  (8'hE1)
  ) u0 (
    .clk (clk), .clk__enable (cen), .reset (rst),
    .ps2_rx_data__valid (vld), .ps2_rx_data__data (dat),
    .ps2_rx_data__parity_error (perr), .ps2_rx_data__protocol_error (prerr),
    .ps2_rx_data__timeout (tmo), .ps2_key_ack (ack), .overflow_clear (oclr),
    .ps2_key__valid (v0), .ps2_key__extended (x0), .ps2_key__release (r0),
    .ps2_key__key_number (k0), .fifo_count (c0), .overflow (o0), .error_count (e0)
  );

  ps2_host_keyboard_queue #(
    .FIFO_DEPTH_LOG2 (3),
    .FILTER_REPEATS  (1'b1),
    .PAUSE_KEY_CODE  (8'hE1)
  ) u1 (
    .clk (clk), .clk__enable (cen), .reset (rst),
    .ps2_rx_data__valid (vld), .ps2_rx_data__data (dat),
    .ps2_rx_data__parity_error (perr), .ps2_rx_data__protocol_error (prerr),
    .ps2_rx_data__timeout (tmo), .ps2_key_ack (ack), .overflow_clear (oclr),
    .ps2_key__valid (v1), .ps2_key__extended (x1), .ps2_key__release (r1),
    .ps2_key__key_number (k1), .fifo_count (c1), .overflow (o1), .error_count (e1)
  );

  // Model state, index 0 = no filter, 1 = filter. Events are {ext, rel, key}.
  logic [9:0] mbuf [2][8];
  int         mhead [2], msize [2], mpause [2], merr [2];
  logic       mext [2], mrel [2], mlmv [2], mov [2];
  logic [8:0] mlm [2];

  int  n_vec = 0, n_err = 0;
  bit  chk_en = 1'b0;

  task automatic model_step(input int i);
    logic       have, drop, push, do_pop, ovset;
    logic [9:0] ev;
    if (rst) begin
      mhead[i] = 0; msize[i] = 0; mpause[i] = 0; merr[i] = 0;
      mext[i] = 0; mrel[i] = 0; mlmv[i] = 0; mov[i] = 0; mlm[i] = '0;
      return;
    end
    if (!cen) return;
    do_pop = (msize[i] > 0) && ack;
    have = 0; drop = 0; push = 0; ovset = 0; ev = '0;
    if (vld) begin
      if (perr || prerr || tmo) begin
        if (merr[i] < 255) merr[i]++;
        mext[i] = 0; mrel[i] = 0; mpause[i] = 0;
      end else if (mpause[i] > 0) begin
        mpause[i]--;
        if (mpause[i] == 0) begin have = 1; ev = {2'b00, 8'hE1}; end
      end else if (dat == 8'hE0) mext[i] = 1;
      else if (dat == 8'hF0) mrel[i] = 1;
      else if (dat == 8'hE1 && !mrel[i]) mpause[i] = 7;
      else begin
        have = 1; ev = {mext[i], mrel[i], dat}; mext[i] = 0; mrel[i] = 0;
      end
    end
    if (have) begin
      if (!ev[8]) begin
        if (i == 1 && mlmv[i] && mlm[i] == {ev[9], ev[7:0]}) drop = 1;
        else begin mlmv[i] = 1; mlm[i] = {ev[9], ev[7:0]}; end
      end else if (mlmv[i] && mlm[i] == {ev[9], ev[7:0]}) mlmv[i] = 0;
      if (!drop) begin
        if (msize[i] < 8 || do_pop) push = 1;
        else ovset = 1;
      end
    end
    if (do_pop) begin mhead[i] = (mhead[i] + 1) % 8; msize[i]--; end
    if (push) begin mbuf[i][(mhead[i] + msize[i]) % 8] = ev; msize[i]++; end
    if (oclr) mov[i] = 0;
    if (ovset) mov[i] = 1;
  endtask

  function automatic logic [23:0] exp_vec(input int i);
    logic [9:0] h;
    h = (msize[i] > 0) ? mbuf[i][mhead[i]] : 10'h0;
    return {msize[i] > 0, h, 4'(msize[i]), mov[i], 8'(merr[i])};
  endfunction

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if ({v0, x0, r0, k0, c0, o0, e0} !== exp_vec(0)) begin
        n_err++;
        $display("FAIL cycle_nofilter t=%0t got=%h want=%h", $time,
                 {v0, x0, r0, k0, c0, o0, e0}, exp_vec(0));
      end
      n_vec++;
      if ({v1, x1, r1, k1, c1, o1, e1} !== exp_vec(1)) begin
        n_err++;
        $display("FAIL cycle_filter t=%0t got=%h want=%h", $time,
                 {v1, x1, r1, k1, c1, o1, e1}, exp_vec(1));
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic [2:0] e,
                     input logic a, input logic oc, input logic ce, input logic rs);
    vld = v; dat = d; {perr, prerr, tmo} = e; ack = a; oclr = oc; cen = ce; rst = rs;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #2;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input logic a, input logic oc);
    cyc(1'b0, 8'h00, 3'b000, a, oc, 1'b1, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 10; k++) idle(1'b1, 1'b0);
  endtask

  initial begin
    cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_en = 1'b1;
    lit("reset_outputs", {v0, x0, r0, k0, c0, o0, e0}, 32'h0);

    // Make then break of 1C; valid the cycle after the first byte.
    send(8'h1C);
    lit("t1_valid", v0, 1);
    lit("t1_head", {x0, r0, k0}, 10'h01C);
    send(8'hF0);
    send(8'h1C);
    lit("t1_count", c0, 2);
    lit("t1_model_count", msize[0], 2);
    idle(1'b1, 1'b0);
    lit("t1_break", {x0, r0, k0}, 10'h11C);
    drain();

    // Extended break, then orphan E0 aborted by an error byte.
    send(8'hE0); send(8'hF0); send(8'h75);
    lit("t2_count", c0, 1);
    lit("t2_head", {x0, r0, k0}, 10'h375);
    drain();
    send(8'hE0);
    cyc(1'b1, 8'h33, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
    lit("t2_err_count", e0, 1);
    lit("t2_no_event", c0, 0);

    // Pause sequence collapses to one event.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    lit("t3_count", c0, 1);
    lit("t3_head", {x0, r0, k0}, 10'h0E1);
    drain();

    // Overflow with ten makes into an eight-deep queue.
    for (int k = 0; k < 10; k++) send(8'(8'h10 + k));
    lit("t4_count", c0, 8);
    lit("t4_overflow", o0, 1);
    for (int k = 0; k < 8; k++) begin
      lit("t4_pop_order", k0, 8'(8'h10 + k));
      idle(1'b1, 1'b0);
    end
    lit("t4_empty", v0, 0);
    idle(1'b0, 1'b1);
    lit("t4_ovf_clear", o0, 0);

    // Full queue with a pop on the same edge as a new emit.
    for (int k = 0; k < 8; k++) send(8'(8'h20 + k));
    cyc(1'b1, 8'h28, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    lit("t6_count", c0, 8);
    lit("t6_overflow", o0, 0);
    lit("t6_head", k0, 8'h21);
    drain();

    // Repeat filter: 1C 1C 1C F0 1C 1C.
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    lit("t5_count_nofilter", c0, 5);
    lit("t5_count_filter", c1, 3);
    lit("t5_f_ev0", {x1, r1, k1}, 10'h01C);
    idle(1'b1, 1'b0);
    lit("t5_f_ev1", {x1, r1, k1}, 10'h11C);
    idle(1'b1, 1'b0);
    lit("t5_f_ev2", {x1, r1, k1}, 10'h01C);
    drain();

    // Reset in the middle of a Pause sequence.
    send(8'hE1); send(8'h14);
    cyc(1'b1, 8'h77, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    lit("t7_reset_count", c0, 0);
    send(8'h1C);
    lit("t7_after_reset", {v0, x0, r0, k0}, 11'h41C);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      logic       v, a, oc, ce, rs;
      logic [7:0] d;
      logic [2:0] e;
      int         r;
      r  = $urandom_range(0, 9);
      d  = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : (r == 2) ? 8'hE1 :
           (r < 5) ? 8'h1C : 8'($urandom);
      v  = ($urandom_range(0, 9) < 4);
      e  = ($urandom_range(0, 19) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
      a  = ($urandom_range(0, 9) < 3);
      oc = ($urandom_range(0, 19) == 0);
      ce = ($urandom_range(0, 9) != 0);
      rs = ($urandom_range(0, 299) == 0);
      cyc(v, d, e, a, oc, ce, rs);
    end

    idle(1'b0, 1'b0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
